// File: rtl/acumulador_productos_pkg.sv
// Shared definitions for the product accumulator.
//   state_t      : FSM state encoding (also driven out on the debug port)
//   acc_width()  : accumulator width from operand width and guard bits
//   count_width(): width of a counter that must hold 0..n_terms
package acumulador_productos_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // A product of two WIDTH-bit operands is 2*WIDTH bits; guard bits
  // absorb the growth from summing several of them.
  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Counter has to reach n_terms itself, hence the +1.
  function automatic int count_width(input int n_terms);
    return $clog2(n_terms + 1);
  endfunction

endpackage

// File: rtl/acumulador_productos_sumador_acc.sv
// Accumulator adder: acc + zero-extended producto, modulo 2^ACC_W.
// Ports:
//   acc      in  ACC_W   current accumulator value
//   producto in  PROD_W  product to add (unsigned)
//   sum      out ACC_W   low ACC_W bits of the sum
//   carry    out 1       carry out of bit ACC_W-1
module sumador_acc #(
  parameter int ACC_W  = 68,
  parameter int PROD_W = 64
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] producto,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] acc_ext;
  logic [ACC_W:0] prod_ext;
  logic [ACC_W:0] sum_full;

  // Size casts zero-extend; this also works when there are no guard
  // bits (PROD_W == ACC_W), where a zero-count replication would not.
  assign acc_ext  = (ACC_W + 1)'(acc);
  assign prod_ext = (ACC_W + 1)'(producto);
  assign sum_full = acc_ext + prod_ext;
  assign sum      = sum_full[ACC_W-1:0];
  assign carry    = sum_full[ACC_W];

endmodule

// File: rtl/acumulador_productos.sv
// Product accumulator (MAC stage). Takes one producto per four-phase
// Done_Flag/ack transfer from the multiplier, sums N_TERMS of them and
// offers the total downstream on result_valid/result_ack.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   producto     in   2*WIDTH product, stable while Done_Flag=1
//   Done_Flag    in   product valid from the multiplier
//   ack          out  product accepted (held until Done_Flag drops)
//   start        in   begin a new accumulation (only honoured in IDLE)
//   acumulado    out  running / final sum, ACC_W bits
//   overflow     out  sticky carry out of ACC_W
//   n_count      out  products accumulated so far
//   result_valid out  acumulado is final and stable
//   result_ack   in   downstream has consumed the result
//   state_dbg    out  current FSM state
//
// Handshakes: upstream is four-phase -- Done_Flag rises, ack rises, Done_Flag
// falls, ack falls; exactly one accumulation happens per Done_Flag pulse.
// Downstream is level based -- result_valid stays high with acumulado frozen
// until result_ack is seen high on a clock edge. All outputs are registered.
module acumulador_productos
  import acumulador_productos_pkg::*;
#(
  parameter int  WIDTH   = 32,
  parameter int  N_TERMS = 8,
  parameter int  GUARD   = 4,
  localparam int ACC_W   = acc_width(WIDTH, GUARD),
  localparam int CNT_W   = count_width(N_TERMS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] producto,
  input  logic               Done_Flag,
  output logic               ack,
  input  logic               start,
  output logic [ACC_W-1:0]   acumulado,
  output logic               overflow,
  output logic [CNT_W-1:0]   n_count,
  output logic               result_valid,
  input  logic               result_ack,
  output state_t             state_dbg
);

  state_t           state_q, state_n;
  logic [ACC_W-1:0] acc_q, acc_n;
  logic             ovf_q, ovf_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             ack_q, ack_n;
  logic             rv_q,  rv_n;

  logic [ACC_W-1:0] sum;
  logic             carry;

  sumador_acc #(
    .ACC_W  (ACC_W),
    .PROD_W (2 * WIDTH)
  ) u_sumador (
    .acc      (acc_q),
    .producto (producto),
    .sum      (sum),
    .carry    (carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      acc_q   <= acc_n;
      ovf_q   <= ovf_n;
      cnt_q   <= cnt_n;
      ack_q   <= ack_n;
      rv_q    <= rv_n;
    end
  end

  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    ovf_n   = ovf_q;
    cnt_n   = cnt_q;
    ack_n   = ack_q;
    rv_n    = rv_q;

    unique case (state_q)
      ST_IDLE: begin
        // Done_Flag is deliberately not acknowledged here so the
        // multiplier stalls until an accumulation is started.
        ack_n = 1'b0;
        rv_n  = 1'b0;
        if (start) begin
          acc_n   = '0;
          ovf_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (Done_Flag) begin
          acc_n   = sum;
          ovf_n   = ovf_q | carry;
          cnt_n   = cnt_q + CNT_W'(1);
          ack_n   = 1'b1;
          state_n = ST_ACK;
        end
      end

      ST_ACK: begin
        // Hold ack until the multiplier drops Done_Flag; no accumulation
        // here, so a long Done_Flag pulse still counts once.
        if (!Done_Flag) begin
          ack_n = 1'b0;
          if (cnt_q == CNT_W'(N_TERMS)) begin
            rv_n    = 1'b1;
            state_n = ST_DONE;
          end else begin
            state_n = ST_WAIT;
          end
        end
      end

      ST_DONE: begin
        // start is ignored here even alongside result_ack; a new run
        // needs a start seen in IDLE.
        if (result_ack) begin
          rv_n    = 1'b0;
          state_n = ST_IDLE;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign ack          = ack_q;
  assign result_valid = rv_q;
  assign acumulado    = acc_q;
  assign overflow     = ovf_q;
  assign n_count      = cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_acumulador_productos.sv
module tb_acumulador_productos;
  import acumulador_productos_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT 1: defaults (WIDTH=32, N_TERMS=8, GUARD=4) ----------------
  logic [63:0] producto;
  logic        done_flag, start, result_ack;
  logic        ack, overflow, result_valid;
  logic [67:0] acumulado;
  logic [3:0]  n_count;
  state_t      st;

  acumulador_productos dut (
    .clk          (clk),
    .reset        (reset),
    .producto     (producto),
    .Done_Flag    (done_flag),
    .ack          (ack),
    .start        (start),
    .acumulado    (acumulado),
    .overflow     (overflow),
    .n_count      (n_count),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .state_dbg    (st)
  );

  // ---------------- DUT 2: GUARD=0, N_TERMS=2 (overflow case) ----------------
  logic [63:0] producto2;
  logic        done_flag2, start2, result_ack2;
  logic        ack2, overflow2, result_valid2;
  logic [63:0] acumulado2;
  logic [1:0]  n_count2;
  state_t      st2;

  acumulador_productos #(.WIDTH(32), .N_TERMS(2), .GUARD(0)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .producto     (producto2),
    .Done_Flag    (done_flag2),
    .ack          (ack2),
    .start        (start2),
    .acumulado    (acumulado2),
    .overflow     (overflow2),
    .n_count      (n_count2),
    .result_valid (result_valid2),
    .result_ack   (result_ack2),
    .state_dbg    (st2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One four-phase transfer on DUT 1 with exact-latency ack checks.
  task automatic xfer(input logic [63:0] p);
    producto  = p;
    done_flag = 1'b1;
    tick();
    check("ack_rise", ack, 1'b1);
    done_flag = 1'b0;
    tick();
    check("ack_fall", ack, 1'b0);
  endtask

  typedef struct {
    logic [63:0] prod;
    logic [67:0] exp_acc;
    logic [3:0]  exp_cnt;
    logic        exp_rv;
    state_t      exp_st;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // k * 0xFFFFFFFE00000001 = k*2^64 - k*2^33 + k
    tbl[0] = '{64'hFFFFFFFE_00000001, 68'h0_FFFFFFFE_00000001, 4'd1, 1'b0, ST_WAIT};
    tbl[1] = '{64'hFFFFFFFE_00000001, 68'h1_FFFFFFFC_00000002, 4'd2, 1'b0, ST_WAIT};
    tbl[2] = '{64'hFFFFFFFE_00000001, 68'h2_FFFFFFFA_00000003, 4'd3, 1'b0, ST_WAIT};
    tbl[3] = '{64'hFFFFFFFE_00000001, 68'h3_FFFFFFF8_00000004, 4'd4, 1'b0, ST_WAIT};
    tbl[4] = '{64'hFFFFFFFE_00000001, 68'h4_FFFFFFF6_00000005, 4'd5, 1'b0, ST_WAIT};
    tbl[5] = '{64'hFFFFFFFE_00000001, 68'h5_FFFFFFF4_00000006, 4'd6, 1'b0, ST_WAIT};
    tbl[6] = '{64'hFFFFFFFE_00000001, 68'h6_FFFFFFF2_00000007, 4'd7, 1'b0, ST_WAIT};
    tbl[7] = '{64'hFFFFFFFE_00000001, 68'h7_FFFFFFF0_00000008, 4'd8, 1'b1, ST_DONE};

    // ---- reset with Done_Flag and start asserted ----
    reset       = 1'b0;
    producto    = 64'(32'($urandom_range(1, 1000)));
    done_flag   = 1'b1;
    start       = 1'b1;
    result_ack  = 1'b0;
    producto2   = '0;
    done_flag2  = 1'b0;
    start2      = 1'b0;
    result_ack2 = 1'b0;
    repeat (3) tick();
    check("rst_ack",  ack, 1'b0);
    check("rst_rv",   result_valid, 1'b0);
    check("rst_acc",  acumulado, 68'h0);
    check("rst_ovf",  overflow, 1'b0);
    check("rst_cnt",  n_count, 4'd0);
    check("rst_state", st, ST_IDLE);
    start     = 1'b0;
    done_flag = 1'b0;
    reset     = 1'b1;
    tick();

    // ---- Done_Flag in IDLE is ignored ----
    producto  = 64'd5;
    done_flag = 1'b1;
    repeat (3) tick();
    check("idle_no_ack", ack, 1'b0);
    check("idle_no_acc", acumulado, 68'h0);
    check("idle_no_cnt", n_count, 4'd0);
    check("idle_state",  st, ST_IDLE);
    done_flag = 1'b0;
    tick();

    // ---- full run from the table ----
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_state", st, ST_WAIT);
    for (int i = 0; i < 8; i++) begin
      xfer(tbl[i].prod);
      check("run_acc",   acumulado, tbl[i].exp_acc);
      check("run_cnt",   n_count, tbl[i].exp_cnt);
      check("run_ovf",   overflow, 1'b0);
      check("run_rv",    result_valid, tbl[i].exp_rv);
      check("run_state", st, tbl[i].exp_st);
    end

    // ---- DONE ignores start and Done_Flag; result held until ack ----
    start     = 1'b1;
    done_flag = 1'b1;
    repeat (3) tick();
    check("done_rv_hold", result_valid, 1'b1);
    check("done_no_ack",  ack, 1'b0);
    check("done_acc",     acumulado, 68'h7_FFFFFFF0_00000008);
    check("done_cnt",     n_count, 4'd8);
    check("done_state",   st, ST_DONE);
    done_flag  = 1'b0;
    // start and result_ack together: result_ack wins, lands in IDLE
    result_ack = 1'b1;
    tick();
    start      = 1'b0;
    result_ack = 1'b0;
    check("rack_rv",    result_valid, 1'b0);
    check("rack_state", st, ST_IDLE);
    check("rack_acc",   acumulado, 68'h7_FFFFFFF0_00000008);
    check("rack_cnt",   n_count, 4'd8);
    tick();
    check("idle_retain_state", st, ST_IDLE);
    check("idle_retain_acc",   acumulado, 68'h7_FFFFFFF0_00000008);

    // ---- long Done_Flag pulse counts once ----
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_acc", acumulado, 68'h0);
    producto  = 64'h10;
    done_flag = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_ack", ack, 1'b1);
      check("hold_cnt", n_count, 4'd1);
      check("hold_acc", acumulado, 68'h10);
    end
    done_flag = 1'b0;
    tick();
    check("hold_ack_fall", ack, 1'b0);
    check("hold_state",    st, ST_WAIT);

    // ---- asynchronous reset mid-transfer ----
    xfer(64'h20);
    xfer(64'h30);
    check("mid_acc", acumulado, 68'h60);
    check("mid_cnt", n_count, 4'd3);
    producto  = 64'h40;
    done_flag = 1'b1;
    tick();
    check("mid_ack", ack, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_ack",   ack, 1'b0);
    check("arst_acc",   acumulado, 68'h0);
    check("arst_cnt",   n_count, 4'd0);
    check("arst_state", st, ST_IDLE);
    done_flag = 1'b0;
    tick();
    reset = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) xfer(64'h1);
    check("ones_acc", acumulado, 68'h8);
    check("ones_cnt", n_count, 4'd8);
    check("ones_rv",  result_valid, 1'b1);
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ones_rv_clear", result_valid, 1'b0);

    // ---- overflow on GUARD=0, N_TERMS=2 ----
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      producto2  = 64'hFFFFFFFE_00000001;
      done_flag2 = 1'b1;
      tick();
      check("ovf_ack_rise", ack2, 1'b1);
      done_flag2 = 1'b0;
      tick();
      check("ovf_ack_fall", ack2, 1'b0);
      if (i == 0) begin
        check("ovf_first_acc", acumulado2, 64'hFFFFFFFE_00000001);
        check("ovf_first_flag", overflow2, 1'b0);
      end
    end
    check("ovf_acc", acumulado2, 64'hFFFFFFFC_00000002);
    check("ovf_flag", overflow2, 1'b1);
    check("ovf_rv",   result_valid2, 1'b1);
    check("ovf_cnt",  n_count2, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
